alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  command valid; sampled only in IDLE.
REQ-005 op  in  3  operation code, captured with start.
REQ-006 a  in  4  operand A, captured with start.
REQ-007 b  in  4  operand B, captured with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 result  out  8  registered result; held between operations.

Function
REQ-011 FSM states SHALL be IDLE, EXEC, MUL and DONE.
REQ-012 IDLE with start=1: on that edge, register op, a and b; go to MUL if op=100, else to EXEC.
REQ-013 Opcodes, all unsigned:
- 000: result={3'b000,carry,sum} of a+b (4-bit ripple add, carry-in 0).
- 001: result=8'h01 if any bit of {a,b} is set, else 8'h00.
- 010: result=8'h01 if all bits of {a,b} are set, else 8'h00.
- 011: result={a,b}.
- 100: result=a*b.
- 101: result=(result+{4'h0,a}) mod 256.
- 110/111: result=8'h00.
REQ-014 EXEC: write result on the next edge, then go to DONE; op 101 SHALL use the result value held before this operation.
REQ-015 MUL: run exactly 4 iterations using a 2-bit counter i=0..3.
- Each iteration: if b_reg[i]=1, product += a_reg<<i.
- After iteration 3: write product to result, go to DONE.
- The product register SHALL be cleared on entry to MUL.
REQ-016 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-017 Latency, counted from the start edge: done SHALL be high during the 2nd cycle for non-multiply ops and during the 5th cycle for multiply; result SHALL be valid while done=1.
REQ-018 start while busy=1 (including the DONE cycle) SHALL be ignored and not queued.
REQ-019 done and busy SHALL both be high in the DONE cycle; busy SHALL drop in the cycle after done.
REQ-020 result SHALL change only on the edge that leaves EXEC or leaves the last MUL iteration.
REQ-021 All additions SHALL wrap modulo 2^width; no overflow flag.

Reset
REQ-022 reset=1 SHALL, on that edge, force: state=IDLE, result=8'h00, done=0, busy=0, counter=0, product=0 and all operand registers=0.
REQ-023 reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.

Structure
REQ-024 A shared package alu_pkg SHALL hold:
- the op enum: OP_ADD, OP_OR, OP_AND, OP_CAT, OP_MUL, OP_ACC;
- the state enum;
- constant MUL_STEPS=4.
REQ-025 One sub-module, alu_core, SHALL hold the combinational single-cycle functions (ops 000-011, and 110/111 returning 0).
REQ-026 The FSM, multiply iteration and accumulate logic SHALL stay in alu_sequencer.

Verification
REQ-027 op=000, a=F, b=1 -> result=8'h10 and done high in the 2nd cycle after the start edge; busy high for 2 cycles.
REQ-028 op=100, a=F, b=F -> result=8'hE1 and done in the 5th cycle; busy high for 5 cycles; result unchanged during iterations.
REQ-029 Run op=001 with a=0, b=0, then op=010 with a=F, b=F, then op=011 with a=A, b=5 -> results 8'h00, 8'h01, 8'hA5.
REQ-030 Accumulate and wrap:
- After reset, op=101 with a=9, three times -> 8'h09, 8'h12, 8'h1B.
- op=011 with a=F, b=F, then op=101 with a=1 -> 8'h00.
REQ-031 Reset and ignored start:
- Start op=100, assert reset during MUL iteration 2 -> next cycle busy=0, result=8'h00, no done pulse.
- start pulsed while busy -> ignored, no second done.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states, multiply step count.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_OR  = 3'b001,
    OP_AND = 3'b010,
    OP_CAT = 3'b011,
    OP_MUL = 3'b100,
    OP_ACC = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } state_e;

  localparam int unsigned MUL_STEPS = 4;
  localparam logic [1:0]  MUL_LAST  = 2'(MUL_STEPS - 1);

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU functions; opcodes handled in the sequencer return zero here.
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] result_o
);

  logic [4:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    result_o = 8'h00;
    case (op_i)
      OP_ADD:  result_o = {3'b000, sum};
      OP_OR:   result_o = {7'h00, |{a_i, b_i}};
      OP_AND:  result_o = {7'h00, &{a_i, b_i}};
      OP_CAT:  result_o = {a_i, b_i};
      default: result_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer: captures an operation, runs it in one EXEC cycle or four shift-add MUL
// iterations, then pulses done for one cycle.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] prod_q, prod_d;
  logic [7:0] result_q, result_d;
  logic [7:0] core_result;
  logic [7:0] prod_sum;

  alu_core u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (core_result)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    // Partial product for the current iteration: add a shifted by the bit position.
    prod_sum = prod_q + (b_q[cnt_q] ? ({4'h0, a_q} << cnt_q) : 8'h00);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op_e'(op);
          a_d     = a;
          b_d     = b;
          cnt_d   = 2'd0;
          prod_d  = 8'h00;
          state_d = (op == OP_MUL) ? StMul : StExec;
        end
      end
      StExec: begin
        result_d = (op_q == OP_ACC) ? result_q + {4'h0, a_q} : core_result;
        state_d  = StDone;
      end
      StMul: begin
        prod_d = prod_sum;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == MUL_LAST) begin
          result_d = prod_sum;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OP_ADD;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      cnt_q    <= 2'd0;
      prod_q   <= 8'h00;
      result_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
